// File: rtl/mpy_result_fifo_if.sv
// Handshake bundle between the multiplier result FIFO and its producer/consumer.
// Optional accumulator signals exist only when MPY_RESULT_ACC_EN is defined.
interface mpy_result_fifo_if #(
  parameter int PW    = 64,
  parameter int DEPTH = 4,
  parameter int DCW   = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]  Product;
  logic           Product_Valid;
  logic [PW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  count;
  logic           full;
  logic           overflow;
  logic [DCW-1:0] drop_cnt;
  logic           clr_ovf;
`ifdef MPY_RESULT_ACC_EN
  logic           acc_clr;
  logic [PW+7:0]  acc_sum;

  modport slave (
    input  Product, Product_Valid, out_ready, clr_ovf, acc_clr,
    output out_data, out_valid, count, full, overflow, drop_cnt, acc_sum
  );
  modport master (
    output Product, Product_Valid, out_ready, clr_ovf, acc_clr,
    input  out_data, out_valid, count, full, overflow, drop_cnt, acc_sum
  );
`else
  modport slave (
    input  Product, Product_Valid, out_ready, clr_ovf,
    output out_data, out_valid, count, full, overflow, drop_cnt
  );
  modport master (
    output Product, Product_Valid, out_ready, clr_ovf,
    input  out_data, out_valid, count, full, overflow, drop_cnt
  );
`endif
endinterface

// File: rtl/mpy_result_fifo.sv
// First-word-fall-through result buffer behind the shift-add multiplier; counts dropped products.
// Optional running sum of accepted products is enabled by defining MPY_RESULT_ACC_EN.
module mpy_result_fifo #(
  parameter int DEPTH = 4,
  parameter int PW    = 64,
  parameter int DCW   = 8
) (
  input logic              CLK,
  input logic              RST,
  mpy_result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q, full_d;
  logic           valid_q, valid_d;
  logic           ovf_q, ovf_d;
  logic [DCW-1:0] drop_q, drop_d;
  logic [PW-1:0]  head_q, head_d;

  logic push, pop, drop;

  // The multiplier cannot stall, so a slot freed by a same-cycle pop is reusable.
  assign pop  = valid_q && bus.out_ready;
  assign push = bus.Product_Valid && (!full_q || pop);
  assign drop = bus.Product_Valid && full_q && !pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    valid_d = (count_d != '0);

    // A product landing in an otherwise empty buffer bypasses the storage read.
    head_d = head_q;
    if (count_d != '0) begin
      head_d = (push && count_d == CW'(1)) ? bus.Product : mem_q[rd_ptr_d];
    end

    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = bus.clr_ovf ? DCW'(1) : ((drop_q == '1) ? drop_q : drop_q + DCW'(1));
    end else if (bus.clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.Product;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      head_q   <= head_d;
    end
  end

  assign bus.out_data  = head_q;
  assign bus.out_valid = valid_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;
  assign bus.drop_cnt  = drop_q;

`ifdef MPY_RESULT_ACC_EN
  logic [PW+7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (push) begin
      acc_d = bus.acc_clr ? {8'd0, bus.Product} : acc_q + {8'd0, bus.Product};
    end else if (bus.acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bus.acc_sum = acc_q;
`endif
endmodule
